vc_input_buffer: RTL

//  Write side of the per-input-port VC buffers. Accepts flits from the upstream link.
//  On each head flit it allocates a free VC and latches the packet's one-hot out direction.
//  It stores the packet's flits in that VC's FIFO and pops flits when the downstream VC

---
 rtl/vc_input_buffer.sv | 152 +++++++++++++++
 1 files changed

// File: rtl/vc_input_buffer.sv
// Input-port VC buffer: allocates a free VC on each head flit, stores the packet's flits
// in that VC's FIFO, and pops flits for the VC named by the downstream selector.
module vc_input_buffer #(
    parameter int NUM_VC     = 4,
    parameter int NUM_PORTS  = 4,
    parameter int VC_DEPTH   = 4,
    parameter int FLIT_WIDTH = 32,
    parameter int VC_BITS    = $clog2(NUM_VC),
    parameter int CNT_BITS   = $clog2(VC_DEPTH) + 1
) (
    input  logic                                 clk,
    input  logic                                 reset,
    input  logic                                 in_valid,
    output logic                                 in_ready,
    input  logic [FLIT_WIDTH-1:0]                in_flit,
    input  logic                                 in_head,
    input  logic                                 in_tail,
    input  logic [NUM_PORTS-1:0]                 in_direction,
    input  logic                                 rd_en,
    input  logic [VC_BITS-1:0]                   rd_vc,
    output logic                                 out_valid,
    output logic [FLIT_WIDTH-1:0]                out_flit,
    output logic                                 out_tail,
    output logic [NUM_VC-1:0][NUM_PORTS-1:0]     vc_direction,
    output logic [NUM_VC-1:0]                    vc_empty,
    output logic [NUM_VC-1:0]                    vc_busy,
    output logic                                 proto_err
);

    localparam int PTR_BITS = CNT_BITS - 1;

    logic                                r_wr_active;
    logic [VC_BITS-1:0]                  r_wr_vc;
    logic                                r_proto_err;
    logic [FLIT_WIDTH:0]                 r_mem [NUM_VC][VC_DEPTH];

    logic [NUM_VC-1:0]                   w_busy;
    logic [NUM_VC-1:0]                   w_alloc;
    logic [NUM_VC-1:0]                   w_wr;
    logic [NUM_VC-1:0]                   w_pop;
    logic [NUM_VC-1:0][CNT_BITS-1:0]     w_cnt;
    logic [NUM_VC-1:0][PTR_BITS-1:0]     w_wptr;
    logic [NUM_VC-1:0][PTR_BITS-1:0]     w_rptr;
    logic [VC_BITS-1:0]                  w_free_idx;
    logic [VC_BITS-1:0]                  w_wr_target;
    logic                                w_accept;
    logic                                w_head_alloc;
    logic                                w_drop;
    logic                                w_head_err;
    logic                                w_wr_fire;
    logic [FLIT_WIDTH:0]                 w_rd_word;

    // Lowest-index idle VC wins allocation.
    always_comb begin
        w_free_idx = '0;
        for (int i = NUM_VC - 1; i >= 0; i--) begin
            if (!w_busy[i]) begin
                w_free_idx = VC_BITS'(i);
            end
        end
    end

    // Mid-packet readiness ignores a same-cycle pop on the target VC.
    assign in_ready     = r_wr_active ? (w_cnt[r_wr_vc] < CNT_BITS'(VC_DEPTH)) : (|(~w_busy));
    assign w_accept     = in_valid & in_ready;
    assign w_head_alloc = w_accept & ~r_wr_active & in_head;
    assign w_drop       = w_accept & ~r_wr_active & ~in_head;
    assign w_head_err   = w_accept & r_wr_active & in_head;
    assign w_wr_fire    = w_accept & (r_wr_active | in_head);
    assign w_wr_target  = r_wr_active ? r_wr_vc : w_free_idx;

    assign out_valid = rd_en & ~vc_empty[rd_vc];
    assign w_rd_word = r_mem[rd_vc][w_rptr[rd_vc]];
    assign out_flit  = w_rd_word[FLIT_WIDTH-1:0];
    assign out_tail  = w_rd_word[FLIT_WIDTH];
    assign vc_busy   = w_busy;
    assign proto_err = r_proto_err;

    always_ff @(posedge clk) begin
        if (!reset) begin
            r_wr_active <= 1'b0;
            r_wr_vc     <= '0;
            r_proto_err <= 1'b0;
        end else begin
            r_proto_err <= w_drop | w_head_err;
            if (w_head_alloc) begin
                r_wr_active <= ~in_tail;
                r_wr_vc     <= w_free_idx;
            end else if (w_accept && r_wr_active && in_tail) begin
                r_wr_active <= 1'b0;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (w_wr_fire) begin
            r_mem[w_wr_target][w_wptr[w_wr_target]] <= {in_tail, in_flit};
        end
    end

    generate
        for (genvar gi = 0; gi < NUM_VC; gi++) begin : g_vc
            logic                 r_busy;
            logic [NUM_PORTS-1:0] r_dir;
            logic [CNT_BITS-1:0]  r_cnt;
            logic [PTR_BITS-1:0]  r_wptr;
            logic [PTR_BITS-1:0]  r_rptr;

            assign w_alloc[gi] = w_head_alloc & (w_free_idx == VC_BITS'(gi));
            assign w_wr[gi]    = w_wr_fire & (w_wr_target == VC_BITS'(gi));
            assign w_pop[gi]   = out_valid & (rd_vc == VC_BITS'(gi));

            // Release on tail pop; the freed VC is seen idle only from the next cycle.
            always_ff @(posedge clk) begin
                if (!reset) begin
                    r_busy <= 1'b0;
                    r_dir  <= '0;
                    r_cnt  <= '0;
                    r_wptr <= '0;
                    r_rptr <= '0;
                end else begin
                    if (w_alloc[gi]) begin
                        r_busy <= 1'b1;
                        r_dir  <= in_direction;
                    end else if (w_pop[gi] && out_tail) begin
                        r_busy <= 1'b0;
                        r_dir  <= '0;
                    end
                    if (w_wr[gi]) begin
                        r_wptr <= r_wptr + 1'b1;
                    end
                    if (w_pop[gi]) begin
                        r_rptr <= r_rptr + 1'b1;
                    end
                    case ({w_wr[gi], w_pop[gi]})
                        2'b10:   r_cnt <= r_cnt + 1'b1;
                        2'b01:   r_cnt <= r_cnt - 1'b1;
                        default: r_cnt <= r_cnt;
                    endcase
                end
            end

            assign w_busy[gi]       = r_busy;
            assign w_cnt[gi]        = r_cnt;
            assign w_wptr[gi]       = r_wptr;
            assign w_rptr[gi]       = r_rptr;
            assign vc_empty[gi]     = (r_cnt == '0);
            assign vc_direction[gi] = r_dir;
        end
    endgenerate

endmodule
